hawk_trnsl_cache: RTL and testbench
===================================

# hawk_trnsl_cache

Translation front-end placed directly upstream of the page-read manager. It accepts host page-number translation requests and serves them from a small fully-associative cache of hppa→ppa mappings. On a miss it issues a single ATT lookup to the page-read manager, waits for `allow_access`, then fills the cache and returns the translated page. Table-manager updates invalidate stale entries, so remapped pages (compaction, compression, decompression) are never served from the cache.

## Interface
Parameters:
- `ENTRIES`, 4: number of cache entries; power of two, range 2..16.
- `ADDR_W`, `HACD_AXI4_ADDR_WIDTH`: byte address width.
- `PN_W`, `ADDR_W-12`: page-number width.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk_i`  in  1  clock.
  - `rst_ni`  in  1  asynchronous active-low reset.
- Request side:
  - `req_valid_i`  in  1  translation request.
  - `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
  - `req_hppa_i`  in  PN_W  host page number.
  - `req_zero_blk_i`  in  1  access is a zero-block write.
- Translation output:
  - `trnsl_valid_o`  out  1  translation available.
  - `trnsl_ppn_o`  out  PN_W  physical page number.
  - `trnsl_ready_i`  in  1  consumer takes the translation.
- Page-read-manager lookup:
  - `lookup_o`  out  1  one-cycle lookup pulse.
  - `lookup_hppa_o`  out  PN_W  page number for the lookup.
  - `lookup_zero_blk_o`  out  1  zero-block flag for the lookup.
  - `pgrd_ready_i`  in  1  page-read manager idle.
- Page-read-manager response:
  - `allow_access_i`  in  1  one-cycle pulse: the mapping is valid.
  - `ppa_i`  in  ADDR_W  translated byte address; bits [11:0] ignored.
  - `sts_i`  in  2  ATT status (`hacd_pkg` STS_* encoding).
- Invalidation:
  - `inv_i`  in  1  invalidate the entry matching `inv_hppa_i`.
  - `inv_hppa_i`  in  PN_W  page number to invalidate.
  - `flush_i`  in  1  invalidate all entries.
- Debug:
  - `tc_state_o`  out  3  current FSM state.

## Operation
- Storage: per entry, `valid`, `tag[PN_W]`, `ppn[PN_W]`.
  - Replacement is round-robin through `fill_ptr` (clog2(ENTRIES) bits, wraps ENTRIES-1→0).
  - An invalid entry, lowest index first, is preferred over `fill_ptr`. `fill_ptr` advances only when it is used.
- FSM states: IDLE=0, HIT_OUT=1, MISS_REQ=2, MISS_WAIT=3, RESP_OUT=4.
- IDLE:
  - `req_ready_o`=1.
  - On acceptance, capture hppa and zero_blk, then compare against all valid tags.
  - Hit and `req_zero_blk_i`=0 → HIT_OUT.
  - Otherwise → MISS_REQ. Zero-block writes always take the miss path so the page-read manager can update zpd_cnt.
- HIT_OUT: `trnsl_valid_o`=1, `trnsl_ppn_o`=the cached ppn. On `trnsl_ready_i` → IDLE.
- MISS_REQ:
  - `lookup_hppa_o` and `lookup_zero_blk_o` are driven from the captured request.
  - When `pgrd_ready_i`=1, pulse `lookup_o` for exactly one cycle → MISS_WAIT.
- MISS_WAIT:
  - `lookup_hppa_o` and `lookup_zero_blk_o` stay stable.
  - On `allow_access_i`: latch `ppa_i[ADDR_W-1:12]`.
  - Fill the cache only if `sts_i`∈{STS_UNCOMP, STS_INCOMP} and the kill flag is clear.
  - → RESP_OUT.
- RESP_OUT: present the latched ppn. On `trnsl_ready_i` → IDLE.
- Kill flag:
  - Set during MISS_REQ or MISS_WAIT if `flush_i`=1, or `inv_i`=1 with `inv_hppa_i` equal to the captured hppa.
  - Cleared on entry to MISS_REQ.
  - A killed miss still returns its ppn to the requester but is not cached.
- Invalidate on the same cycle as a fill to the same tag: invalidate wins, and the entry ends invalid.
- `flush_i` clears every valid bit in one cycle, in any state.
- Duplicate tags are never created. A fill whose tag is already present overwrites that entry.

## Timing
- Reset values:
  - `req_ready_o`=0 during reset, 1 in IDLE after reset.
  - All other outputs 0. All valid bits 0, `fill_ptr`=0, state=IDLE.
- Hit latency: request accepted at cycle N → `trnsl_valid_o` at N+1. Back-to-back hits give one translation every 2 cycles.
- Miss: `lookup_o` is asserted on the first MISS_REQ cycle with `pgrd_ready_i`=1, i.e. N+1 at the earliest.
- Response: `trnsl_valid_o` follows `allow_access_i` by 1 cycle.
- All outputs are registered. `trnsl_valid_o` holds, with stable data, until `trnsl_ready_i`.
- Invalidate takes effect for lookups accepted in the cycle after `inv_i`.
- Asynchronous reset mid-miss: everything returns to reset values. Any outstanding page-read-manager response is ignored while in IDLE.
- `allow_access_i` outside MISS_WAIT is ignored.

## Configuration
- `HAWK_TRNSL_CACHE_EN` defined: cache storage and hit path are present, as described above.
- Not defined:
  - No storage is built; every request takes MISS_REQ→MISS_WAIT→RESP_OUT.
  - `inv_i` and `flush_i` are ignored.
  - Port list and response timing are unchanged.

## Test plan
- Cold miss, hppa=0x80010, `pgrd_ready_i`=1, `allow_access_i` 5 cycles after `lookup_o`, `ppa_i`=0x1234_5000, sts=STS_UNCOMP → exactly one `lookup_o` pulse, `trnsl_ppn_o`=0x12345. A repeat request gives `trnsl_valid_o` at N+1 with no lookup.
- Fill ENTRIES+1 distinct pages, then re-request the first → a miss, evicted round-robin; the others still hit.
- Miss returning sts=STS_COMP → translation delivered, no fill; a second request again issues a lookup.
- `inv_i` with the matching hppa during MISS_WAIT → response delivered, entry not cached. `flush_i` after 3 fills → all subsequent requests miss.
- Zero-block write to a cached page → `lookup_o` asserted, `lookup_zero_blk_o`=1; `lookup_hppa_o` stable until `allow_access_i`.
- `pgrd_ready_i` held 0 for 20 cycles, then `rst_ni` asserted mid-MISS_WAIT → no lookup before ready; after reset all outputs 0 and the cache empty.

Source files
------------

// File: rtl/hawk_trnsl_cache.sv
// hawk_trnsl_cache: translation front-end for the page-read manager.
// Serves hppa->ppn translations from a small fully-associative cache and
// falls back to a single ATT lookup on a miss.
// Build option: define HAWK_TRNSL_CACHE_EN to build the cache storage and
// hit path. Without it every request takes the lookup path and inv_i /
// flush_i are ignored; ports and response timing are identical.

`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif

module hawk_trnsl_cache #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned ADDR_W  = `HACD_AXI4_ADDR_WIDTH,
    parameter int unsigned PN_W    = ADDR_W - 12
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // request side
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [PN_W-1:0] req_hppa_i,
    input  logic            req_zero_blk_i,
    // translation output
    output logic            trnsl_valid_o,
    output logic [PN_W-1:0] trnsl_ppn_o,
    input  logic            trnsl_ready_i,
    // page-read-manager lookup
    output logic            lookup_o,
    output logic [PN_W-1:0] lookup_hppa_o,
    output logic            lookup_zero_blk_o,
    input  logic            pgrd_ready_i,
    // page-read-manager response
    input  logic            allow_access_i,
    input  logic [ADDR_W-1:0] ppa_i,
    input  logic [1:0]      sts_i,
    // invalidation
    input  logic            inv_i,
    input  logic [PN_W-1:0] inv_hppa_i,
    input  logic            flush_i,
    // debug
    output logic [2:0]      tc_state_o
);

    // ATT status encoding, mirrors hacd_pkg
    localparam logic [1:0] STS_UNCOMP = 2'b00;
    localparam logic [1:0] STS_COMP   = 2'b01;
    localparam logic [1:0] STS_INCOMP = 2'b10;

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HIT_OUT   = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_RESP_OUT  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_trnsl_valid;
    logic [PN_W-1:0]   r_trnsl_ppn;
    logic              r_lookup;
    logic [PN_W-1:0]   r_lookup_hppa;   // captured request page number
    logic              r_lookup_zb;
    logic              r_kill;          // miss must not be cached

    logic              w_accept;
    logic              w_hit;
    logic [PN_W-1:0]   w_hit_ppn;
    logic              w_kill_now;
    logic              w_unused_ppa_lo;

    assign w_accept        = req_valid_i & r_req_ready;
    assign w_unused_ppa_lo = ^ppa_i[11:0];

`ifdef HAWK_TRNSL_CACHE_EN
    logic [ENTRIES-1:0] r_valid;
    logic [PN_W-1:0]    r_tag     [ENTRIES];
    logic [PN_W-1:0]    r_ppn_mem [ENTRIES];
    logic [IDX_W-1:0]   r_fill_ptr;

    logic               w_sts_ok;
    logic               w_fill;
    logic               w_match;
    logic [IDX_W-1:0]   w_match_idx;
    logic               w_free;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_fill_idx;
    logic               w_fill_from_ptr;

    assign w_sts_ok   = (sts_i == STS_UNCOMP) || (sts_i == STS_INCOMP);
    assign w_kill_now = ((r_state == ST_MISS_REQ) || (r_state == ST_MISS_WAIT)) &&
                        (flush_i || (inv_i && (inv_hppa_i == r_lookup_hppa)));
    // a same-cycle kill also blocks the fill, so invalidate wins over fill
    assign w_fill     = (r_state == ST_MISS_WAIT) && allow_access_i && w_sts_ok &&
                        !r_kill && !w_kill_now;

    // hit search against the incoming request
    always_comb begin
        w_hit     = 1'b0;
        w_hit_ppn = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_hit && r_valid[i] && (r_tag[i] == req_hppa_i)) begin
                w_hit     = 1'b1;
                w_hit_ppn = r_ppn_mem[i];
            end
        end
    end

    // fill target: existing tag, else lowest invalid entry, else round-robin
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_match && r_valid[i] && (r_tag[i] == r_lookup_hppa)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!w_free && !r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        w_fill_from_ptr = !w_match && !w_free;
        if (w_match)
            w_fill_idx = w_match_idx;
        else if (w_free)
            w_fill_idx = w_free_idx;
        else
            w_fill_idx = r_fill_ptr;
    end

    // cache storage: fill, then invalidate/flush override the valid bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= '0;
            r_fill_ptr <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_tag[i]     <= '0;
                r_ppn_mem[i] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_valid[w_fill_idx]   <= 1'b1;
                r_tag[w_fill_idx]     <= r_lookup_hppa;
                r_ppn_mem[w_fill_idx] <= ppa_i[ADDR_W-1:12];
                if (w_fill_from_ptr)
                    r_fill_ptr <= r_fill_ptr + 1'b1;
            end
            if (flush_i) begin
                r_valid <= '0;
            end else if (inv_i) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (r_tag[i] == inv_hppa_i)
                        r_valid[i] <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_nocache;

    assign w_hit            = 1'b0;
    assign w_hit_ppn        = '0;
    assign w_kill_now       = 1'b0;
    assign w_unused_nocache = ^{inv_i, inv_hppa_i, flush_i, sts_i, r_kill,
                                STS_COMP, STS_UNCOMP, STS_INCOMP};
`endif

    // control FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_trnsl_valid <= 1'b0;
            r_trnsl_ppn   <= '0;
            r_lookup      <= 1'b0;
            r_lookup_hppa <= '0;
            r_lookup_zb   <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready   <= 1'b0;
                        r_lookup_hppa <= req_hppa_i;
                        r_lookup_zb   <= req_zero_blk_i;
                        // zero-block writes always go to the page-read manager
                        if (w_hit && !req_zero_blk_i) begin
                            r_state       <= ST_HIT_OUT;
                            r_trnsl_valid <= 1'b1;
                            r_trnsl_ppn   <= w_hit_ppn;
                        end else begin
                            r_state  <= ST_MISS_REQ;
                            r_kill   <= 1'b0;
                            r_lookup <= pgrd_ready_i;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_HIT_OUT, ST_RESP_OUT: begin
                    if (trnsl_ready_i) begin
                        r_trnsl_valid <= 1'b0;
                        r_req_ready   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_MISS_REQ: begin
                    if (w_kill_now)
                        r_kill <= 1'b1;
                    // lookup pulse is a registered copy of pgrd_ready_i
                    if (r_lookup) begin
                        r_lookup <= 1'b0;
                        r_state  <= ST_MISS_WAIT;
                    end else if (pgrd_ready_i) begin
                        r_lookup <= 1'b1;
                    end
                end
                ST_MISS_WAIT: begin
                    if (w_kill_now)
                        r_kill <= 1'b1;
                    if (allow_access_i) begin
                        r_trnsl_ppn   <= ppa_i[ADDR_W-1:12];
                        r_trnsl_valid <= 1'b1;
                        r_state       <= ST_RESP_OUT;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o       = r_req_ready;
    assign trnsl_valid_o     = r_trnsl_valid;
    assign trnsl_ppn_o       = r_trnsl_ppn;
    assign lookup_o          = r_lookup;
    assign lookup_hppa_o     = r_lookup_hppa;
    assign lookup_zero_blk_o = r_lookup_zb;
    assign tc_state_o        = r_state;

endmodule

// File: tb/tb_hawk_trnsl_cache.sv
// Self-checking bench for hawk_trnsl_cache: table of translation requests
// with a ppn scoreboard, plus hand-written reset-mid-miss sequence.
module tb_hawk_trnsl_cache;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned PN_W    = 52;

    localparam logic [1:0] STS_UNCOMP = 2'b00;
    localparam logic [1:0] STS_COMP   = 2'b01;
    localparam logic [1:0] STS_INCOMP = 2'b10;

`ifdef HAWK_TRNSL_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready_o;
    logic [PN_W-1:0]   req_hppa;
    logic              req_zb;
    logic              trnsl_valid_o;
    logic [PN_W-1:0]   trnsl_ppn_o;
    logic              trnsl_ready;
    logic              lookup_o;
    logic [PN_W-1:0]   lookup_hppa_o;
    logic              lookup_zb_o;
    logic              pgrd_ready;
    logic              allow_access;
    logic [ADDR_W-1:0] ppa;
    logic [1:0]        sts;
    logic              inv;
    logic [PN_W-1:0]   inv_hppa;
    logic              flush;
    logic [2:0]        tc_state_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_lookups = 0;

    hawk_trnsl_cache #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .PN_W    (PN_W)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .req_hppa_i        (req_hppa),
        .req_zero_blk_i    (req_zb),
        .trnsl_valid_o     (trnsl_valid_o),
        .trnsl_ppn_o       (trnsl_ppn_o),
        .trnsl_ready_i     (trnsl_ready),
        .lookup_o          (lookup_o),
        .lookup_hppa_o     (lookup_hppa_o),
        .lookup_zero_blk_o (lookup_zb_o),
        .pgrd_ready_i      (pgrd_ready),
        .allow_access_i    (allow_access),
        .ppa_i             (ppa),
        .sts_i             (sts),
        .inv_i             (inv),
        .inv_hppa_i        (inv_hppa),
        .flush_i           (flush),
        .tc_state_o        (tc_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count lookup pulses, one per cycle they are high
    always @(posedge clk) begin
        if (lookup_o)
            n_lookups <= n_lookups + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [PN_W-1:0]   hppa;
        bit                zb;
        logic [1:0]        sts;
        logic [ADDR_W-1:0] ppa;
        int unsigned       delay;  // cycles from lookup pulse to allow_access
        int unsigned       act;    // 0 none,1 inv in wait,2 flush in wait,3 inv idle,4 flush idle
        bit                hit;    // expected hit with cache built
    } vec_t;

    vec_t              tbl[$];
    logic [PN_W-1:0]   exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [PN_W-1:0] hppa, input bit zb, input logic [1:0] s,
                       input logic [ADDR_W-1:0] p, input int unsigned d,
                       input int unsigned a, input bit h);
        vec_t v;
        v.hppa = hppa; v.zb = zb; v.sts = s; v.ppa = p; v.delay = d; v.act = a; v.hit = h;
        tbl.push_back(v);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int unsigned idx);
        bit               exp_hit;
        bit               ok;
        int unsigned      l0;
        logic [PN_W-1:0]  exp_ppn;
        exp_hit = v.hit && CACHE_ON;
        @(negedge clk);
        if (v.act == 3 || v.act == 4) begin
            inv      = (v.act == 3);
            flush    = (v.act == 4);
            inv_hppa = v.hppa;
            @(negedge clk);
            inv   = 1'b0;
            flush = 1'b0;
        end
        wait_ready(ok);
        if (!ok) begin
            chk($sformatf("v%0d_ready_timeout", idx), 0, 1);
            return;
        end
        l0        = n_lookups;
        req_valid = 1'b1;
        req_hppa  = v.hppa;
        req_zb    = v.zb;
        exp_q.push_back(v.ppa[ADDR_W-1:12]);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_hit) begin
            chk($sformatf("v%0d_hit_valid", idx), trnsl_valid_o, 1);
            chk($sformatf("v%0d_hit_state", idx), tc_state_o, 1);
            chk($sformatf("v%0d_hit_nolookup", idx), lookup_o, 0);
        end else begin
            chk($sformatf("v%0d_lookup", idx), lookup_o, 1);
            chk($sformatf("v%0d_lookup_hppa", idx), lookup_hppa_o, v.hppa);
            chk($sformatf("v%0d_lookup_zb", idx), lookup_zb_o, v.zb);
            for (int unsigned d = 1; d <= v.delay; d++) begin
                @(negedge clk);
                inv   = 1'b0;
                flush = 1'b0;
                if (d == 1 && (v.act == 1 || v.act == 2)) begin
                    inv      = (v.act == 1);
                    flush    = (v.act == 2);
                    inv_hppa = v.hppa;
                end
                if (lookup_o !== 1'b0 || lookup_hppa_o !== v.hppa || lookup_zb_o !== v.zb ||
                    tc_state_o !== 3'd3)
                    chk($sformatf("v%0d_wait_stable_d%0d", idx, d),
                        {lookup_o, lookup_zb_o, tc_state_o, lookup_hppa_o},
                        {1'b0, v.zb, 3'd3, v.hppa});
                if (d == v.delay) begin
                    allow_access = 1'b1;
                    ppa          = v.ppa;
                    sts          = v.sts;
                end
            end
            @(negedge clk);
            inv          = 1'b0;
            flush        = 1'b0;
            allow_access = 1'b0;
            ppa          = '1;
            sts          = STS_COMP;
            chk($sformatf("v%0d_resp_valid", idx), trnsl_valid_o, 1);
            chk($sformatf("v%0d_resp_state", idx), tc_state_o, 4);
        end
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d_scoreboard_empty", idx), 0, 1);
            exp_ppn = '0;
        end else begin
            exp_ppn = exp_q.pop_front();
        end
        chk($sformatf("v%0d_ppn", idx), trnsl_ppn_o, exp_ppn);
        @(negedge clk);
        chk($sformatf("v%0d_hold", idx), {trnsl_valid_o, trnsl_ppn_o}, {1'b1, exp_ppn});
        trnsl_ready = 1'b1;
        @(negedge clk);
        trnsl_ready = 1'b0;
        chk($sformatf("v%0d_done", idx), {trnsl_valid_o, req_ready_o, tc_state_o}, {1'b0, 1'b1, 3'd0});
        chk($sformatf("v%0d_nlookups", idx), n_lookups - l0, exp_hit ? 0 : 1);
    endtask

    localparam logic [PN_W-1:0] PA = 'h80010, PB = 'h80020, PC = 'h80030, PD = 'h80040,
                                PE = 'h80050, PF = 'h80060, PG = 'h80070, PH = 'h80080,
                                PK = 'h800A0;

    initial begin
        bit ok;
        bit saw_early;
        rst_n = 1'b0; req_valid = 1'b0; req_hppa = '0; req_zb = 1'b0; trnsl_ready = 1'b0;
        pgrd_ready = 1'b1; allow_access = 1'b0; ppa = '0; sts = STS_UNCOMP;
        inv = 1'b0; inv_hppa = '0; flush = 1'b0;

        //   hppa zb sts          ppa               dly act hit
        add(PA, 0, STS_UNCOMP, 64'h1234_5000, 5, 0, 0);
        add(PA, 0, STS_UNCOMP, 64'h1234_5000, 3, 0, 1);
        add(PB, 0, STS_UNCOMP, 64'h2222_2000, 3, 0, 0);
        add(PC, 0, STS_UNCOMP, 64'h3333_3000, 2, 0, 0);
        add(PD, 0, STS_UNCOMP, 64'h4444_4000, 4, 0, 0);
        add(PE, 0, STS_UNCOMP, 64'h5555_5000, 3, 0, 0);
        add(PB, 0, STS_UNCOMP, 64'h2222_2000, 3, 0, 1);
        add(PC, 0, STS_UNCOMP, 64'h3333_3000, 3, 0, 1);
        add(PD, 0, STS_UNCOMP, 64'h4444_4000, 3, 0, 1);
        add(PE, 0, STS_UNCOMP, 64'h5555_5000, 3, 0, 1);
        add(PA, 0, STS_UNCOMP, 64'h1234_5000, 3, 0, 0);
        add(PA, 0, STS_UNCOMP, 64'h1234_5000, 3, 0, 1);
        add(PF, 0, STS_COMP,   64'h6666_6000, 3, 0, 0);
        add(PF, 0, STS_UNCOMP, 64'h6666_7000, 3, 0, 0);
        add(PF, 0, STS_UNCOMP, 64'h6666_7000, 3, 0, 1);
        add(PG, 0, STS_INCOMP, 64'h7777_7000, 3, 0, 0);
        add(PG, 0, STS_INCOMP, 64'h7777_7000, 3, 0, 1);
        add(PA, 1, STS_UNCOMP, 64'h0AAA_AFFF, 4, 0, 0);
        add(PA, 0, STS_UNCOMP, 64'h0AAA_A000, 3, 0, 1);
        add(PE, 0, STS_UNCOMP, 64'h5555_5000, 3, 0, 1);
        add(PH, 0, STS_UNCOMP, 64'h8888_8000, 3, 1, 0);
        add(PH, 0, STS_UNCOMP, 64'h8888_8000, 3, 0, 0);
        add(PH, 0, STS_UNCOMP, 64'h8888_8000, 3, 0, 1);
        add(PG, 0, STS_UNCOMP, 64'h7777_7000, 3, 3, 0);
        add(PF, 0, STS_UNCOMP, 64'h6666_7000, 3, 2, 0);
        add(PA, 0, STS_UNCOMP, 64'h0AAA_A000, 3, 0, 0);
        add(PH, 0, STS_UNCOMP, 64'h8888_8000, 3, 0, 0);
        add(PG, 0, STS_UNCOMP, 64'h7777_7000, 3, 0, 0);
        add(PA, 0, STS_UNCOMP, 64'h0ABC_D000, 3, 4, 0);
        add(PH, 0, STS_UNCOMP, 64'h8888_8000, 3, 0, 0);
        add(PG, 0, STS_UNCOMP, 64'h7777_7000, 3, 0, 0);
        add(PA, 0, STS_UNCOMP, 64'h0ABC_D000, 3, 0, 1);

        repeat (3) @(negedge clk);
        chk("rst_outputs", {req_ready_o, trnsl_valid_o, lookup_o, lookup_zb_o, tc_state_o},
            {1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        chk("rst_ppn_hppa", {trnsl_ppn_o, lookup_hppa_o}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {req_ready_o, tc_state_o}, {1'b1, 3'd0});

        for (int unsigned i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], i);

        // page-read manager busy, then reset in the middle of the miss
        @(negedge clk);
        wait_ready(ok);
        chk("rstmiss_ready", ok, 1);
        pgrd_ready = 1'b0;
        req_valid  = 1'b1;
        req_hppa   = PK;
        req_zb     = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmiss_state_req", tc_state_o, 2);
        saw_early = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lookup_o) saw_early = 1'b1;
        end
        chk("rstmiss_no_early_lookup", saw_early, 0);
        pgrd_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (lookup_o) ok = 1'b1;
        end
        chk("rstmiss_lookup_seen", ok, 1);
        @(negedge clk);
        chk("rstmiss_state_wait", tc_state_o, 3);
        rst_n = 1'b0;
        #1;
        chk("rstmiss_outputs", {req_ready_o, trnsl_valid_o, lookup_o, lookup_zb_o, tc_state_o},
            {1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        chk("rstmiss_ppn_hppa", {trnsl_ppn_o, lookup_hppa_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        allow_access = 1'b1;
        ppa          = 64'h9999_9000;
        sts          = STS_UNCOMP;
        @(negedge clk);
        allow_access = 1'b0;
        chk("stray_allow_ignored", {trnsl_valid_o, req_ready_o, tc_state_o}, {1'b0, 1'b1, 3'd0});

        // cache must be empty after reset
        begin
            vec_t v;
            v.hppa = PA; v.zb = 0; v.sts = STS_UNCOMP; v.ppa = 64'h0123_4000;
            v.delay = 2; v.act = 0; v.hit = 0;
            run_vec(v, 100);
            v.hit = 1;
            run_vec(v, 101);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
